// File: rtl/tone_pkg.sv
// Shared definitions for the tone-comparator interface.
//   Holds the default data widths, the frame length, the reference and
//   target bin index tables and the collector state encoding. The tone
//   collector (producer) and the tone comparator (consumer) both import
//   this package so they agree on widths and table layout.
package tone_pkg;

  localparam int MAG_W  = 24;
  localparam int OUT_W  = 31;
  localparam int NBINS  = 256;
  localparam int NTONES = 6;

  // Bin 64 appears in both tables on purpose: one spectral line can serve
  // as a reference tone and as a target tone at the same time.
  localparam int REF_IDX [NTONES] = '{4, 8, 16, 32, 64, 128};
  localparam int TGT_IDX [NTONES] = '{20, 40, 64, 100, 200, 255};

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} tbc_state_e;

  // Slots 0..NTONES-1 are the reference tones, the rest are target tones.
  function automatic int slot_idx(input int slot);
    return (slot < NTONES) ? REF_IDX[slot] : TGT_IDX[slot - NTONES];
  endfunction

endpackage

// File: rtl/tone_bin_collector_sat_acc.sv
// sat_acc: saturating accumulator register with synchronous clear.
//   Adds add_val to the running total whenever en is high and clamps at the
//   all-ones value instead of wrapping.
// Ports:
//   clk      in   1      rising-edge clock
//   rst_n    in   1      synchronous reset, active low (clears the total)
//   clr      in   1      synchronous clear of the total
//   en       in   1      add add_val at this edge
//   add_val  in   OUT_W  addend (unsigned)
//   acc_nxt  out  OUT_W  value the total takes at the coming edge
module sat_acc #(
  parameter int OUT_W = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] add_val,
  output logic [OUT_W-1:0] acc_nxt
);

  logic [OUT_W-1:0] acc;
  logic [OUT_W:0]   sum;

  // The extra carry bit of the sum tells us the add overflowed, in which
  // case the total sticks at the maximum representable value.
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, add_val};
    acc_nxt = acc;
    if (en) begin
      acc_nxt = sum[OUT_W] ? '1 : sum[OUT_W-1:0];
    end
  end

  // The running total itself; clear wins over accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      acc <= '0;
    end else begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/tone_bin_collector.sv
// tone_bin_collector: producer side of the tone-comparator interface.
//   Takes one frame of per-bin power magnitudes streamed serially (bin index
//   is the beat order), sums the whole frame with saturation, captures the
//   six reference-tone and six target-tone bins, and presents all thirteen
//   values in parallel together with a one-cycle out_en strobe.
// Ports:
//   clk         in   1        rising-edge clock
//   rst_n       in   1        synchronous reset, active low
//   s_valid     in   1        magnitude beat valid
//   s_ready     out  1        collector accepts a beat (low only in EMIT)
//   s_mag       in   MAG_W    bin power magnitude (unsigned)
//   s_last      in   1        beat is the last bin of the frame
//   energy_tot  out  OUT_W    saturating sum of the frame
//   ref_bin     out  6*OUT_W  reference tones, tone k at [k*OUT_W +: OUT_W]
//   tgt_bin     out  6*OUT_W  target tones, same packing
//   out_en      out  1        outputs hold a new complete frame
//   frame_err   out  1        only with FRAME_LEN_CHECK_EN: frame length was
//                             not NBINS, frame dropped
// Configuration macro: FRAME_LEN_CHECK_EN enables the frame length check.
module tone_bin_collector import tone_pkg::*; #(
  parameter int MAG_W = tone_pkg::MAG_W,
  parameter int NBINS = tone_pkg::NBINS,
  parameter int OUT_W = tone_pkg::OUT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [MAG_W-1:0]      s_mag,
  input  logic                  s_last,
  output logic [OUT_W-1:0]      energy_tot,
  output logic [6*OUT_W-1:0]    ref_bin,
  output logic [6*OUT_W-1:0]    tgt_bin,
`ifdef FRAME_LEN_CHECK_EN
  output logic                  frame_err,
`endif
  output logic                  out_en
);

  localparam int CNT_W = $clog2(NBINS);
  localparam int NSLOT = 2 * NTONES;

  tbc_state_e               state;
  logic [CNT_W-1:0]         bin_cnt;
  logic                     past_end;
  logic                     xfer;
  logic [OUT_W-1:0]         mag_ext;
  logic [OUT_W-1:0]         energy_nxt;
  logic [NSLOT-1:0][OUT_W-1:0] slot_nxt;

  assign xfer    = s_valid && s_ready;
  assign mag_ext = OUT_W'(s_mag);

  // Frame energy. The adder result for the current edge is taken straight
  // into the output register when the last beat is accepted, so the last
  // beat is already included when out_en rises.
  sat_acc #(.OUT_W(OUT_W)) u_energy (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state == EMIT),
    .en      (xfer),
    .add_val (mag_ext),
    .acc_nxt (energy_nxt)
  );

  // One work register per table entry. A slot loads the beat whose index
  // matches its table entry; past_end blocks captures once the bin counter
  // has hit its ceiling so overlong frames cannot overwrite the last bin.
  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    localparam int IDX = slot_idx(g);
    logic [OUT_W-1:0] work_q;
    logic [OUT_W-1:0] work_d;

    always_comb begin
      work_d = work_q;
      if (xfer && !past_end && (bin_cnt == CNT_W'(IDX))) begin
        work_d = mag_ext;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n || (state == EMIT)) begin
        work_q <= '0;
      end else begin
        work_q <= work_d;
      end
    end

    assign slot_nxt[g] = work_d;
  end

`ifdef FRAME_LEN_CHECK_EN
  localparam int BCNT_W = $clog2(NBINS + 1);
  logic [BCNT_W-1:0] beat_cnt;
  logic              len_ok;

  // The beat counter saturates at NBINS, so only a frame whose last beat
  // arrives with exactly NBINS-1 earlier beats is considered well formed.
  assign len_ok = (beat_cnt == BCNT_W'(NBINS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || (state == EMIT)) begin
      beat_cnt <= '0;
    end else if (xfer && (beat_cnt != BCNT_W'(NBINS))) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end
`endif

  // Control FSM with registered handshake, strobe and output values.
  // Outputs are loaded on the edge that accepts the last beat, so they are
  // valid during the EMIT cycle together with out_en; s_ready drops for
  // exactly that cycle while the work registers clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      s_ready    <= 1'b0;
      out_en     <= 1'b0;
      energy_tot <= '0;
      ref_bin    <= '0;
      tgt_bin    <= '0;
      bin_cnt    <= '0;
      past_end   <= 1'b0;
`ifdef FRAME_LEN_CHECK_EN
      frame_err  <= 1'b0;
`endif
    end else begin
      out_en <= 1'b0;
`ifdef FRAME_LEN_CHECK_EN
      frame_err <= 1'b0;
`endif
      case (state)
        IDLE, ACCUM: begin
          s_ready <= 1'b1;
          if (xfer) begin
            if (bin_cnt == CNT_W'(NBINS - 1)) begin
              past_end <= 1'b1;
            end else begin
              bin_cnt <= bin_cnt + 1'b1;
            end
            if (s_last) begin
              state   <= EMIT;
              s_ready <= 1'b0;
`ifdef FRAME_LEN_CHECK_EN
              if (len_ok) begin
                out_en     <= 1'b1;
                energy_tot <= energy_nxt;
                ref_bin    <= slot_nxt[NTONES-1:0];
                tgt_bin    <= slot_nxt[NSLOT-1:NTONES];
              end else begin
                frame_err  <= 1'b1;
              end
`else
              out_en     <= 1'b1;
              energy_tot <= energy_nxt;
              ref_bin    <= slot_nxt[NTONES-1:0];
              tgt_bin    <= slot_nxt[NSLOT-1:NTONES];
`endif
            end else begin
              state <= ACCUM;
            end
          end
        end
        EMIT: begin
          state    <= IDLE;
          s_ready  <= 1'b1;
          bin_cnt  <= '0;
          past_end <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
